// File: rtl/layer_ctrl_rf_if.sv
// MBus receive/transmit word bundle between the bus layer and layer_ctrl_rf.
// master = bus layer side, slave = the register-file controller.
interface layer_ctrl_rf_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_pend;
    logic                  rx_req;
    logic                  rx_broadcast;
    logic                  rx_fail;
    logic                  rx_ack;

    logic [ADDR_WIDTH-1:0] tx_addr;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_pend;
    logic                  tx_req;
    logic                  tx_priority;
    logic                  tx_ack;
    logic                  tx_succ;
    logic                  tx_fail;
    logic                  tx_resp_ack;

    modport master (
        output rx_addr, rx_data, rx_pend, rx_req, rx_broadcast, rx_fail,
        output tx_ack, tx_succ, tx_fail,
        input  rx_ack, tx_addr, tx_data, tx_pend, tx_req, tx_priority, tx_resp_ack
    );

    modport slave (
        input  rx_addr, rx_data, rx_pend, rx_req, rx_broadcast, rx_fail,
        input  tx_ack, tx_succ, tx_fail,
        output rx_ack, tx_addr, tx_data, tx_pend, tx_req, tx_priority, tx_resp_ack
    );
endinterface

// File: rtl/layer_ctrl_rf.sv
// MBus register-file controller: function 0 writes one entry, function 1 reads
// a run of entries back as a multi-word reply.
//
// state     | meaning
// IDLE      | waiting for an RX word (or RX_FAIL)
// RX_HOLD   | RX_ACK high, waiting for RX_REQ/RX_FAIL to drop
// RD_ISSUE  | load next reply word onto TX outputs
// TX_HOLD   | TX_REQ high, waiting for TX_ACK (or TX_FAIL abort)
// TX_ACKLOW | waiting for TX_ACK to drop before next word
// TX_RESP   | acknowledging TX_SUCC/TX_FAIL
module layer_ctrl_rf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 4,
    parameter int RF_NUM     = 8,
    parameter int RF_WIDTH   = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    layer_ctrl_rf_if.slave             bus,
    input  logic [RF_NUM*RF_WIDTH-1:0] rf_in,
    output logic [RF_WIDTH-1:0]        rf_out,
    output logic [RF_NUM-1:0]          rf_load,
    output logic                       busy
);
    typedef enum logic [2:0] {
        IDLE,
        RX_HOLD,
        RD_ISSUE,
        TX_HOLD,
        TX_ACKLOW,
        TX_RESP
    } state_t;

    state_t          state;
    logic [7:0]      rd_idx;
    logic [8:0]      words_left;
    logic [7:0]      dest;
    logic            is_read;

    logic [FUNC_WIDTH-1:0] rx_func;
    logic [7:0]            rx_idx;
    logic                  wr_hit;
    logic                  rd_next;
    logic [RF_NUM-1:0]     load_mask;
    logic [RF_WIDTH-1:0]   rd_word;
    logic [23:0]           reply_payload;
    logic                  unused_bits;

    assign rx_func       = bus.rx_addr[FUNC_WIDTH-1:0];
    assign rx_idx        = bus.rx_data[31:24];
    assign wr_hit        = (rx_func == '0) && !bus.rx_broadcast && !bus.rx_fail
                           && (int'(rx_idx) < RF_NUM);
    assign rd_next       = (rx_func == FUNC_WIDTH'(1)) && !bus.rx_broadcast && !bus.rx_fail;
    assign reply_payload = 24'(rd_word);
    assign busy          = (state != IDLE);
    assign bus.tx_priority = 1'b0;
    assign unused_bits   = ^{bus.rx_pend, bus.rx_addr, bus.rx_data};

    // Index decode for the write strobe and the read mux; out-of-range reads give 0.
    always_comb begin
        load_mask = '0;
        rd_word   = '0;
        for (int i = 0; i < RF_NUM; i++) begin
            if (int'(rx_idx) == i) load_mask[i] = wr_hit;
            if (int'(rd_idx) == i) rd_word = rf_in[i*RF_WIDTH +: RF_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rd_idx          <= '0;
            words_left      <= '0;
            dest            <= '0;
            is_read         <= 1'b0;
            rf_out          <= '0;
            rf_load         <= '0;
            bus.rx_ack      <= 1'b0;
            bus.tx_addr     <= '0;
            bus.tx_data     <= '0;
            bus.tx_pend     <= 1'b0;
            bus.tx_req      <= 1'b0;
            bus.tx_resp_ack <= 1'b0;
        end else begin
            rf_load <= '0;
            case (state)
                IDLE: begin
                    if (bus.rx_req || bus.rx_fail) begin
                        bus.rx_ack <= 1'b1;
                        rd_idx     <= bus.rx_data[31:24];
                        words_left <= {1'b0, bus.rx_data[23:16]} + 9'd1;
                        dest       <= bus.rx_data[15:8];
                        is_read    <= rd_next;
                        if (wr_hit) begin
                            rf_out  <= bus.rx_data[RF_WIDTH-1:0];
                            rf_load <= load_mask;
                        end
                        state <= RX_HOLD;
                    end
                end
                RX_HOLD: begin
                    if (!bus.rx_req && !bus.rx_fail) begin
                        bus.rx_ack <= 1'b0;
                        state      <= is_read ? RD_ISSUE : IDLE;
                    end
                end
                RD_ISSUE: begin
                    bus.tx_addr <= ADDR_WIDTH'(dest);
                    bus.tx_data <= DATA_WIDTH'({rd_idx, reply_payload});
                    bus.tx_pend <= (words_left != 9'd1);
                    bus.tx_req  <= 1'b1;
                    state       <= TX_HOLD;
                end
                TX_HOLD: begin
                    if (bus.tx_fail) begin
                        bus.tx_req      <= 1'b0;
                        bus.tx_pend     <= 1'b0;
                        bus.tx_resp_ack <= 1'b1;
                        state           <= TX_RESP;
                    end else if (bus.tx_ack) begin
                        bus.tx_req <= 1'b0;
                        rd_idx     <= rd_idx + 8'd1;
                        words_left <= words_left - 9'd1;
                        state      <= TX_ACKLOW;
                    end
                end
                TX_ACKLOW: begin
                    if (bus.tx_fail) begin
                        bus.tx_pend     <= 1'b0;
                        bus.tx_resp_ack <= 1'b1;
                        state           <= TX_RESP;
                    end else if (!bus.tx_ack) begin
                        state <= (words_left == 9'd0) ? TX_RESP : RD_ISSUE;
                    end
                end
                TX_RESP: begin
                    if (bus.tx_succ || bus.tx_fail) begin
                        bus.tx_resp_ack <= 1'b1;
                    end else if (bus.tx_resp_ack) begin
                        bus.tx_resp_ack <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
